// File: rtl/computie_bus_pkg.sv
// Shared types and constants for the Computie bus target controller.
// Optional feature macro used by the controller: COMPUTIE_BUS_TIMEOUT_EN.
package computie_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA   = 3'd2,
    ST_REQ    = 3'd3,
    ST_ACK    = 3'd4,
    ST_ERR    = 3'd5,
    ST_IGNORE = 3'd6
  } state_e;

  localparam logic STROBE_ACTIVE = 1'b0;
  localparam logic RW_READ       = 1'b1;

endpackage

// File: rtl/computie_bus_window_decode.sv
// Combinational address-window decoder; the lowest-index matching window wins
// and is reported one-hot.
module computie_bus_window_decode #(
  parameter int BITWIDTH    = 32,
  parameter int NUM_WINDOWS = 2
) (
  input  logic [BITWIDTH-1:0]             addr_i,
  input  logic [NUM_WINDOWS*BITWIDTH-1:0] base_i,
  input  logic [NUM_WINDOWS*BITWIDTH-1:0] mask_i,
  output logic [NUM_WINDOWS-1:0]          sel_o,
  output logic                            hit_o
);

  always_comb begin
    sel_o = '0;
    hit_o = 1'b0;
    // Walk from the top down so the lowest matching index is written last.
    for (int i = NUM_WINDOWS - 1; i >= 0; i--) begin
      if ((addr_i & mask_i[i*BITWIDTH +: BITWIDTH]) ==
          (base_i[i*BITWIDTH +: BITWIDTH] & mask_i[i*BITWIDTH +: BITWIDTH])) begin
        sel_o    = '0;
        sel_o[i] = 1'b1;
        hit_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/computie_bus_target_ctrl.sv
// Bus target controller: decodes a strobed multiplexed bus cycle into a local
// request/response and acknowledges it. Define COMPUTIE_BUS_TIMEOUT_EN to error out stalled responses.
module computie_bus_target_ctrl
  import computie_bus_pkg::*;
#(
  parameter int  BITWIDTH       = 32,
  parameter int  NUM_WINDOWS    = 2,
  parameter int  TIMEOUT_CYCLES = 16,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            addr_strobe,
  input  logic                            data_strobe,
  input  logic                            read_write,
  input  logic [BITWIDTH-1:0]             from_bus,
  output logic [BITWIDTH-1:0]             to_bus,
  output logic                            demux_oe,
  output logic                            send_receive,
  output logic                            addr_oe,
  output logic                            data_oe,
  output logic                            data_dir,
  output logic                            data_ack,
  output logic                            bus_error,
  input  logic [NUM_WINDOWS*BITWIDTH-1:0] win_base,
  input  logic [NUM_WINDOWS*BITWIDTH-1:0] win_mask,
  output logic                            req_valid,
  output logic                            req_write,
  output logic [NUM_WINDOWS-1:0]          req_sel,
  output logic [BITWIDTH-1:0]             req_addr,
  output logic [BITWIDTH-1:0]             req_wdata,
  input  logic                            rsp_ready,
  input  logic [BITWIDTH-1:0]             rsp_rdata,
  output state_e                          dbg_state,
  output logic [CNT_W-1:0]                dbg_wait_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  // Local handshake: req_valid stays high and req_* stay stable in REQ until the
  // first cycle rsp_ready=1 is sampled; rsp_ready is ignored in every other state.
  state_e                  state_q, state_d;
  logic                    as_q, ds_q, rw_q;
  logic [BITWIDTH-1:0]     bus_q;
  logic [BITWIDTH-1:0]     req_addr_q, req_wdata_q, to_bus_q;
  logic                    req_write_q;
  logic [NUM_WINDOWS-1:0]  req_sel_q, win_sel;
  logic                    win_hit;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  computie_bus_window_decode #(
    .BITWIDTH    (BITWIDTH),
    .NUM_WINDOWS (NUM_WINDOWS)
  ) u_decode (
    .addr_i (req_addr_q),
    .base_i (win_base),
    .mask_i (win_mask),
    .sel_o  (win_sel),
    .hit_o  (win_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q != ST_IDLE && as_q != STROBE_ACTIVE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (as_q == STROBE_ACTIVE) state_d = ST_ADDR;
        ST_ADDR: state_d = win_hit ? ST_DATA : ST_IGNORE;
        ST_DATA: if (ds_q == STROBE_ACTIVE) state_d = ST_REQ;
        ST_REQ: begin
          if (rsp_ready) state_d = ST_ACK;
`ifdef COMPUTIE_BUS_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) state_d = ST_ERR;
`endif
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    addr_oe      = 1'b0;
    data_oe      = 1'b0;
    data_dir     = 1'b0;
    send_receive = 1'b0;
    demux_oe     = 1'b0;
    data_ack     = 1'b1;
    bus_error    = 1'b1;
    req_valid    = 1'b0;
    case (state_q)
      ST_IDLE, ST_ADDR: addr_oe = 1'b1;
      ST_DATA: begin
        data_oe  = 1'b1;
        data_dir = ~req_write_q;
      end
      ST_REQ: begin
        data_oe   = 1'b1;
        data_dir  = ~req_write_q;
        req_valid = 1'b1;
      end
      ST_ACK: begin
        data_oe      = 1'b1;
        data_dir     = ~req_write_q;
        data_ack     = 1'b0;
        send_receive = ~req_write_q;
        demux_oe     = ~req_write_q;
      end
`ifdef COMPUTIE_BUS_TIMEOUT_EN
      ST_ERR: bus_error = 1'b0;
`endif
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (state_q == ST_REQ) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      as_q        <= 1'b1;
      ds_q        <= 1'b1;
      rw_q        <= 1'b0;
      bus_q       <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_write_q <= 1'b0;
      req_sel_q   <= '0;
      to_bus_q    <= '0;
      cnt_q       <= '0;
    end else begin
      as_q  <= addr_strobe;
      ds_q  <= data_strobe;
      rw_q  <= read_write;
      bus_q <= from_bus;
      cnt_q <= cnt_d;
      if (state_q == ST_IDLE && state_d == ST_ADDR) begin
        req_addr_q  <= bus_q;
        req_write_q <= (rw_q != RW_READ);
      end
      if (state_q == ST_ADDR) begin
        req_sel_q <= win_sel;
      end
      if (state_q == ST_DATA && state_d == ST_REQ && req_write_q) begin
        req_wdata_q <= bus_q;
      end
      if (state_q == ST_REQ && state_d == ST_ACK && !req_write_q) begin
        to_bus_q <= rsp_rdata;
      end
    end
  end

  assign to_bus       = to_bus_q;
  assign req_write    = req_write_q;
  assign req_sel      = req_sel_q;
  assign req_addr     = req_addr_q;
  assign req_wdata    = req_wdata_q;
  assign dbg_state    = state_q;
  assign dbg_wait_cnt = cnt_q;

endmodule
